// File: rtl/imem_boot_ctrl.sv
// Instruction-store boot sequencer: streams an image into the SRAM init port (1-cycle accept->write), flushes the PC, then gates run/halt.
// load_ready is high only in LOAD and drops for the final write cycle; IMEM_STEP_EN enables single-step from HALT.
module imem_boot_ctrl #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 32,
  parameter int FLUSH_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              run_req,
  input  logic              halt_req,
  input  logic              step_req,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr,
  output logic [DATA_W-1:0] init_data,
  output logic              chip_enable,
  output logic              core_reset,
  output logic [2:0]        state_o,
  output logic [ADDR_W:0]   load_count,
  output logic              err_overflow
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FLUSH = 3'd2,
    HALT  = 3'd3,
    RUN   = 3'd4,
    STEP  = 3'd5
  } state_t;

  localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [ADDR_W:0] CNT_DEPTH = (ADDR_W+1)'(DEPTH);

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic              last_pend;
  logic [FW-1:0]     flush_cnt;
  logic              accept;

  assign load_ready = (state == LOAD) && !last_pend;
  assign accept     = load_valid && load_ready;
  assign state_o    = state;

`ifndef IMEM_STEP_EN
  logic unused_step;
  assign unused_step = step_req;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      last_pend    <= 1'b0;
      flush_cnt    <= '0;
      init_we      <= 1'b0;
      init_addr    <= '0;
      init_data    <= '0;
      chip_enable  <= 1'b0;
      core_reset   <= 1'b1;
      load_count   <= '0;
      err_overflow <= 1'b0;
    end else begin
      init_we <= 1'b0;
      case (state)
        IDLE: begin
          core_reset  <= 1'b1;
          chip_enable <= 1'b0;
          if (load_start) begin
            state        <= LOAD;
            wr_ptr       <= '0;
            load_count   <= '0;
            err_overflow <= 1'b0;
            last_pend    <= 1'b0;
          end
        end
        LOAD: begin
          chip_enable <= 1'b0;
          if (last_pend) begin
            // final write has now issued; hold the PC in reset for the flush
            state     <= FLUSH;
            flush_cnt <= FW'(FLUSH_CYC - 1);
            last_pend <= 1'b0;
          end else if (accept) begin
            if (load_count < CNT_DEPTH) begin
              init_we     <= 1'b1;
              init_addr   <= wr_ptr;
              init_data   <= load_data;
              chip_enable <= 1'b1;
              wr_ptr      <= wr_ptr + 1'b1;
              load_count  <= load_count + 1'b1;
            end else begin
              err_overflow <= 1'b1;
            end
            if (load_last) last_pend <= 1'b1;
          end
        end
        FLUSH: begin
          if (flush_cnt == '0) begin
            state      <= HALT;
            core_reset <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
        HALT: begin
          if (load_start) begin
            state        <= LOAD;
            core_reset   <= 1'b1;
            wr_ptr       <= '0;
            load_count   <= '0;
            err_overflow <= 1'b0;
            last_pend    <= 1'b0;
          end else if (run_req) begin
            state       <= RUN;
            chip_enable <= 1'b1;
          end
`ifdef IMEM_STEP_EN
          else if (step_req) begin
            state       <= STEP;
            chip_enable <= 1'b1;
          end
`endif
        end
        RUN: begin
          if (halt_req) begin
            state       <= HALT;
            chip_enable <= 1'b0;
          end
        end
`ifdef IMEM_STEP_EN
        STEP: begin
          state       <= HALT;
          chip_enable <= 1'b0;
        end
`endif
        default: begin
          state       <= IDLE;
          core_reset  <= 1'b1;
          chip_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl: load, gapped load, overflow, run/halt, step, mid-op reset.
module tb_imem_boot_ctrl;

  logic        clk = 1'b0;
  logic        reset, load_start, load_valid, load_last;
  logic [31:0] load_data;
  logic        run_req, halt_req, step_req;
  logic        load_ready, init_we, chip_enable, core_reset, err_overflow;
  logic [4:0]  init_addr;
  logic [31:0] init_data;
  logic [2:0]  state_o;
  logic [5:0]  load_count;

  int checks = 0;
  int errors = 0;
  int wr_total = 0;
  int wr_addr0 = 0;
  logic [4:0] wr_last_addr = '0;

  logic [31:0] prog [4];

  always #5 clk = ~clk;

  imem_boot_ctrl dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
    .chip_enable(chip_enable), .core_reset(core_reset), .state_o(state_o),
    .load_count(load_count), .err_overflow(err_overflow)
  );

  always @(posedge clk) begin
    if (init_we) begin
      wr_total     <= wr_total + 1;
      wr_last_addr <= init_addr;
      if (init_addr == 5'd0) wr_addr0 <= wr_addr0 + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] exp, input int max_cyc, input string tag);
    int n;
    n = 0;
    checks++;
    while (state_o !== exp && n < max_cyc) begin
      tick();
      n++;
    end
    if (state_o !== exp) begin
      errors++;
      $error("FAIL %s timeout: state_o=%0d expected=%0d after %0d cycles", tag, state_o, exp, n);
    end
  endtask

  initial begin
    prog[0] = 32'h00500093;
    prog[1] = 32'h00100113;
    prog[2] = 32'h002081B3;
    prog[3] = 32'h0000006F;
    reset = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    load_data = '0; run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;

    repeat (3) tick();
    checks++;
    if (core_reset !== 1'b1 || chip_enable !== 1'b0 || state_o !== 3'd0 ||
        load_ready !== 1'b0 || load_count !== 6'd0) begin
      errors++;
      $error("FAIL reset_state core_reset=%0b chip_enable=%0b state_o=%0d load_ready=%0b load_count=%0d",
             core_reset, chip_enable, state_o, load_ready, load_count);
    end
    checks++; if (core_reset !== 1'b1) begin errors++; $error("FAIL rst_core_reset %0b", core_reset); end
    checks++; if (chip_enable !== 1'b0) begin errors++; $error("FAIL rst_ce %0b", chip_enable); end
    checks++; if (state_o !== 3'd0) begin errors++; $error("FAIL rst_state %0d", state_o); end
    checks++; if (load_ready !== 1'b0) begin errors++; $error("FAIL rst_ready %0b", load_ready); end
    checks++; if (load_count !== 6'd0) begin errors++; $error("FAIL rst_count %0d", load_count); end
    reset = 1'b1;
    run_req = 1'b1;
    tick();
    checks++; if (state_o !== 3'd0) begin errors++; $error("FAIL idle_ignores_run %0d", state_o); end
    run_req = 1'b0;

    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    checks++; if (state_o !== 3'd1) begin errors++; $error("FAIL load_state %0d", state_o); end
    checks++; if (load_ready !== 1'b1) begin errors++; $error("FAIL load_ready %0b", load_ready); end
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1; load_data = prog[i]; load_last = (i == 3);
      tick();
      checks++; if (init_we !== 1'b1) begin errors++; $error("FAIL c_we %0d", i); end
      checks++; if (init_addr !== 5'(i)) begin errors++; $error("FAIL c_addr %0h exp %0h", init_addr, i); end
      checks++; if (init_data !== prog[i]) begin errors++; $error("FAIL c_data %0h exp %0h", init_data, prog[i]); end
      checks++; if (chip_enable !== 1'b1) begin errors++; $error("FAIL c_ce %0d", i); end
    end
    load_valid = 1'b0; load_last = 1'b0;
    checks++; if (load_ready !== 1'b0) begin errors++; $error("FAIL c_ready_drop %0b", load_ready); end
    checks++; if (load_count !== 6'd4) begin errors++; $error("FAIL c_count %0d", load_count); end
    tick();
    checks++; if (state_o !== 3'd2) begin errors++; $error("FAIL flush1_state %0d", state_o); end
    checks++; if (core_reset !== 1'b1) begin errors++; $error("FAIL flush1_rst %0b", core_reset); end
    checks++; if (init_we !== 1'b0) begin errors++; $error("FAIL flush1_we %0b", init_we); end
    tick();
    checks++; if (state_o !== 3'd2) begin errors++; $error("FAIL flush2_state %0d", state_o); end
    checks++; if (core_reset !== 1'b1) begin errors++; $error("FAIL flush2_rst %0b", core_reset); end
    tick();
    checks++; if (state_o !== 3'd3) begin errors++; $error("FAIL halt_state %0d", state_o); end
    checks++; if (core_reset !== 1'b0) begin errors++; $error("FAIL halt_rst %0b", core_reset); end
    checks++; if (chip_enable !== 1'b0) begin errors++; $error("FAIL halt_ce %0b", chip_enable); end

    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    checks++; if (state_o !== 3'd1) begin errors++; $error("FAIL g_state %0d", state_o); end
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1; load_data = prog[i]; load_last = (i == 3);
      tick();
      checks++; if (init_we !== 1'b1) begin errors++; $error("FAIL g_we %0d", i); end
      checks++; if (init_addr !== 5'(i)) begin errors++; $error("FAIL g_addr %0h exp %0h", init_addr, i); end
      checks++; if (init_data !== prog[i]) begin errors++; $error("FAIL g_data %0h exp %0h", init_data, prog[i]); end
      load_valid = 1'b0; load_last = 1'b0; load_data = 32'hDEADBEEF;
      tick();
      checks++; if (init_we !== 1'b0) begin errors++; $error("FAIL g_gap_we %0d", i); end
    end
    checks++; if (load_count !== 6'd4) begin errors++; $error("FAIL g_count %0d", load_count); end
    tick();
    tick();
    checks++; if (state_o !== 3'd3) begin errors++; $error("FAIL g_halt %0d", state_o); end

    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    wr_total = 0; wr_addr0 = 0;
    for (int i = 0; i < 33; i++) begin
      load_valid = 1'b1; load_data = 32'h1000 + 32'(i); load_last = (i == 32);
      tick();
    end
    load_valid = 1'b0; load_last = 1'b0;
    checks++; if (init_we !== 1'b0) begin errors++; $error("FAIL ov_33rd_no_we %0b", init_we); end
    checks++; if (err_overflow !== 1'b1) begin errors++; $error("FAIL ov_err %0b", err_overflow); end
    checks++; if (load_count !== 6'd32) begin errors++; $error("FAIL ov_count %0d", load_count); end
    tick();
    checks++; if (wr_total !== 32) begin errors++; $error("FAIL ov_writes %0d", wr_total); end
    checks++; if (wr_addr0 !== 1) begin errors++; $error("FAIL ov_addr0_once %0d", wr_addr0); end
    checks++; if (wr_last_addr !== 5'd31) begin errors++; $error("FAIL ov_last_addr %0d", wr_last_addr); end
    checks++; if (state_o !== 3'd2) begin errors++; $error("FAIL ov_flush %0d", state_o); end
    tick();
    tick();
    checks++; if (state_o !== 3'd3) begin errors++; $error("FAIL ov_halt %0d", state_o); end
    checks++; if (err_overflow !== 1'b1) begin errors++; $error("FAIL ov_err_sticky %0b", err_overflow); end
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    checks++; if (err_overflow !== 1'b0) begin errors++; $error("FAIL ov_err_clr %0b", err_overflow); end
    load_valid = 1'b1; load_data = prog[0]; load_last = 1'b1;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
    wait_state(3'd3, 6, "ov_reload_halt");

    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    checks++; if (state_o !== 3'd4) begin errors++; $error("FAIL run_state %0d", state_o); end
    checks++; if (chip_enable !== 1'b1) begin errors++; $error("FAIL run_ce %0b", chip_enable); end
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    checks++; if (state_o !== 3'd4) begin errors++; $error("FAIL run_ign_load %0d", state_o); end
    checks++; if (chip_enable !== 1'b1) begin errors++; $error("FAIL run_ce2 %0b", chip_enable); end
    run_req = 1'b1; halt_req = 1'b1;
    tick();
    run_req = 1'b0; halt_req = 1'b0;
    checks++; if (state_o !== 3'd3) begin errors++; $error("FAIL halt_wins_state %0d", state_o); end
    checks++; if (chip_enable !== 1'b0) begin errors++; $error("FAIL halt_wins_ce %0b", chip_enable); end

    step_req = 1'b1;
    tick();
    step_req = 1'b0;
`ifdef IMEM_STEP_EN
    checks++; if (state_o !== 3'd5) begin errors++; $error("FAIL step_state %0d", state_o); end
    checks++; if (chip_enable !== 1'b1) begin errors++; $error("FAIL step_ce %0b", chip_enable); end
`else
    checks++; if (state_o !== 3'd3) begin errors++; $error("FAIL nostep_state %0d", state_o); end
    checks++; if (chip_enable !== 1'b0) begin errors++; $error("FAIL nostep_ce %0b", chip_enable); end
`endif
    tick();
    checks++; if (state_o !== 3'd3) begin errors++; $error("FAIL step_back_state %0d", state_o); end
    checks++; if (chip_enable !== 1'b0) begin errors++; $error("FAIL step_back_ce %0b", chip_enable); end

    load_start = 1'b1; run_req = 1'b1;
    tick();
    load_start = 1'b0; run_req = 1'b0;
    checks++; if (state_o !== 3'd1) begin errors++; $error("FAIL prio_load %0d", state_o); end

    load_valid = 1'b1; load_data = prog[1];
    tick();
    load_valid = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++; if (state_o !== 3'd0) begin errors++; $error("FAIL midrst_state %0d", state_o); end
    checks++; if (core_reset !== 1'b1) begin errors++; $error("FAIL midrst_core_reset %0b", core_reset); end
    checks++; if (init_we !== 1'b0) begin errors++; $error("FAIL midrst_we %0b", init_we); end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_boot_ctrl.md
Name: imem_boot_ctrl

Overview:
Sequencer for the single-cycle core's instruction store and program counter. Accepts a program image over a valid/ready stream and writes it into the instruction SRAM init port at consecutive addresses. It then pulses a core reset to clear the PC and gates the core's chip enable for run, halt and (optionally) single-step. It sits between the host/testbench loader and the datapath's ChipEnable/InitAddr/InstrIn inputs.

Parameters:
ADDR_W, 5, instruction SRAM address width (matches PC width)
DATA_W, 32, instruction word width
DEPTH, 32, number of SRAM words; must be <= 2**ADDR_W
FLUSH_CYC, 2, cycles core_reset is held after a load

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low; reset==0 at a rising edge resets block
load_start  input  1  request to begin loading a new image
load_valid  input  1  load_data beat valid
load_data  input  DATA_W  instruction word
load_last  input  1  marks final beat of image (qualified by load_valid)
load_ready  output  1  controller accepts beat this cycle
run_req  input  1  start/resume execution
halt_req  input  1  stop execution
step_req  input  1  execute one instruction (STEP_EN only)
init_we  output  1  SRAM init write strobe
init_addr  output  ADDR_W  SRAM init address
init_data  output  DATA_W  SRAM init write data
chip_enable  output  1  datapath ChipEnable (PC update + SRAM access)
core_reset  output  1  active-high reset to datapath PC register
state_o  output  3  current state encoding
load_count  output  ADDR_W+1  words written by current/last load
err_overflow  output  1  sticky: beat offered beyond DEPTH

Behaviour:
- Reset values: load_ready=0, init_we=0, init_addr=0, init_data=0, chip_enable=0, core_reset=1, state_o=IDLE, load_count=0, err_overflow=0.
- States and encodings: IDLE=0, LOAD=1, FLUSH=2, HALT=3, RUN=4, STEP=5.
- IDLE: core_reset=1, chip_enable=0. load_start -> LOAD. run_req, halt_req and step_req are ignored.
- LOAD entry: wr_ptr=0, load_count=0, err_overflow cleared. Combinational load_ready=1 while in LOAD.
- Write pipeline: an accepted beat (load_valid&&load_ready) is registered. In the next cycle init_we=1, init_addr=wr_ptr, init_data=load_data, and chip_enable=1 for that write cycle only. wr_ptr and load_count increment on accept. Latency from accept to write is exactly 1 cycle.
- Overflow: a beat accepted when load_count==DEPTH is dropped (no init_we) and sets err_overflow. There is no address wrap and no overwrite of word 0.
- load_last on an accepted beat, or on a dropped overflow beat: the LOAD -> FLUSH transition happens after that beat's write cycle has issued.
- load_start while in LOAD or RUN is ignored.
- FLUSH: core_reset=1, chip_enable=0, held for exactly FLUSH_CYC cycles via a down-counter, then -> HALT.
- HALT: core_reset=0, chip_enable=0. Transitions:
  - run_req -> RUN
  - load_start -> LOAD
  - step_req -> STEP (STEP_EN only)
- Simultaneous requests in HALT: priority is load_start > run_req > step_req.
- RUN: chip_enable=1 every cycle, core_reset=0. halt_req -> HALT; chip_enable is 0 from the next cycle. run_req && halt_req together: halt wins.
- STEP: chip_enable=1 for exactly one cycle, then -> HALT unconditionally.
- Reset mid-operation (any state) returns to IDLE. The partially loaded image is abandoned; the SRAM contents are not cleared.

Optional Feature:
Macro IMEM_STEP_EN.
- Defined: step_req honoured in HALT. STEP state gives a single-cycle chip_enable pulse. Each step_req edge held high produces one step per HALT visit, i.e. a continuous step_req steps every 2 cycles.
- Undefined: the step_req port still exists but is ignored, the STEP state is not synthesised, and encoding 5 is unreachable.

Test Plan:
- Reset: hold reset=0 for 3 cycles -> core_reset=1, chip_enable=0, state_o=0, load_ready=0, load_count=0.
- Load 4 words: load_start, then 0x00500093, 0x00100113, 0x002081B3, 0x0000006F (last) with valid continuous -> init_we pulses 4 cycles, init_addr 0..3 with matching data one cycle after each accept; load_count=4; FLUSH core_reset=1 for 2 cycles; then state_o=3.
- Backpressure/gaps: same 4 words with load_valid toggling every other cycle -> identical writes at addr 0..3, no duplicate or skipped address.
- Overflow: DEPTH=32, send 33 beats with last on 33rd -> 32 writes (addr 0..31), err_overflow=1, no write to addr 0 on 33rd; a new load_start clears err_overflow.
- Run/halt: from HALT pulse run_req -> chip_enable=1 from next cycle; run_req and halt_req same cycle in RUN -> chip_enable=0 next cycle, state_o=3; load_start asserted while in RUN is ignored.
- Step (IMEM_STEP_EN): in HALT, one-cycle step_req -> chip_enable high exactly 1 cycle, state_o 3->5->3; without the macro -> chip_enable stays 0.
